// File: rtl/xnor_gate_bist_if.sv
// Signal bundle between the XOR/XNOR cell self-test block and its surroundings.
// slave is the self-test block's own view; master is the harness view.
interface xnor_gate_bist_if;
    logic       start;
    logic       pwr_good;
    logic       dut_y;
    logic       dut_a;
    logic       dut_b;
    logic [1:0] dut_sel;
    logic       busy;
    logic       done;
    logic       pass;
    logic       aborted;
    logic [7:0] err_count;
    logic       first_fail_valid;
    logic [3:0] first_fail_vec;

    modport slave (
        input  start, pwr_good, dut_y,
        output dut_a, dut_b, dut_sel, busy, done, pass, aborted,
               err_count, first_fail_valid, first_fail_vec
    );

    modport master (
        output start, pwr_good, dut_y,
        input  dut_a, dut_b, dut_sel, busy, done, pass, aborted,
               err_count, first_fail_valid, first_fail_vec
    );
endinterface

// File: rtl/xnor_gate_bist.sv
// Self-test driver/checker for the XOR/XNOR cell: sweeps all 16 {sel,a,b}
// vectors, samples Y after a settle window and records pass/fail results.
module xnor_gate_bist #(
    parameter int SETTLE_CYCLES = 2,
    parameter int PASSES        = 1
) (
    input logic               i_clk,
    input logic               i_reset,
    xnor_gate_bist_if.slave   bist_if
);

    localparam int CNT_W  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int PASS_W = (PASSES > 1) ? $clog2(PASSES) : 1;
    localparam logic [CNT_W-1:0]  SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [PASS_W-1:0] PASS_LAST   = PASS_W'(PASSES - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_CHECK, ST_DONE} state_t;

    state_t            r_state, w_next_state;
    logic [3:0]        r_vec, w_next_vec;
    logic [CNT_W-1:0]  r_settle_cnt, w_next_settle;
    logic [PASS_W-1:0] r_pass_cnt, w_next_pass_cnt;
    logic [7:0]        r_err_count, w_next_err;
    logic              r_ff_valid, w_next_ff_valid;
    logic [3:0]        r_ff_vec, w_next_ff_vec;
    logic              r_aborted, w_next_aborted;
    logic              r_pass, w_next_pass;
    logic              r_busy, r_done;
    logic [3:0]        r_drive;
    logic              w_expected, w_mismatch, w_last_vec, w_busy_next;

    // Vector layout is {sel[1:0], a, b}; sel == 3 selects the XNOR function.
    assign w_expected = (r_vec[3:2] == 2'b11) ? ~(r_vec[1] ^ r_vec[0]) : (r_vec[1] ^ r_vec[0]);
    assign w_mismatch = (bist_if.dut_y !== w_expected);
    assign w_last_vec = (r_vec == 4'hF) && (r_pass_cnt == PASS_LAST);
    assign w_busy_next = (w_next_state == ST_SETTLE) || (w_next_state == ST_CHECK);

    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    always_comb begin
        w_next_state    = r_state;
        w_next_vec      = r_vec;
        w_next_settle   = r_settle_cnt;
        w_next_pass_cnt = r_pass_cnt;
        w_next_err      = r_err_count;
        w_next_ff_valid = r_ff_valid;
        w_next_ff_vec   = r_ff_vec;
        w_next_aborted  = r_aborted;
        w_next_pass     = r_pass;
        unique case (r_state)
            ST_IDLE: begin
                if (bist_if.start && bist_if.pwr_good) begin
                    w_next_state    = ST_SETTLE;
                    w_next_vec      = 4'h0;
                    w_next_settle   = '0;
                    w_next_pass_cnt = '0;
                    w_next_err      = 8'h00;
                    w_next_ff_valid = 1'b0;
                    w_next_ff_vec   = 4'h0;
                    w_next_aborted  = 1'b0;
                    w_next_pass     = 1'b0;
                end
            end
            ST_SETTLE: begin
                if (!bist_if.pwr_good) begin
                    w_next_state   = ST_DONE;
                    w_next_aborted = 1'b1;
                end else if (r_settle_cnt == SETTLE_LAST) begin
                    w_next_state  = ST_CHECK;
                    w_next_settle = '0;
                end else begin
                    w_next_settle = r_settle_cnt + CNT_W'(1);
                end
            end
            ST_CHECK: begin
                if (!bist_if.pwr_good) begin
                    // Sample taken during a supply drop is discarded.
                    w_next_state   = ST_DONE;
                    w_next_aborted = 1'b1;
                end else begin
                    if (w_mismatch) begin
                        if (r_err_count != 8'hFF) w_next_err = r_err_count + 8'd1;
                        if (!r_ff_valid) begin
                            w_next_ff_valid = 1'b1;
                            w_next_ff_vec   = r_vec;
                        end
                    end
                    if (w_last_vec) begin
                        w_next_state = ST_DONE;
                    end else begin
                        w_next_state = ST_SETTLE;
                        w_next_vec   = r_vec + 4'd1;
                        if (r_vec == 4'hF) w_next_pass_cnt = r_pass_cnt + PASS_W'(1);
                    end
                end
            end
            ST_DONE: w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
        if (w_next_state == ST_DONE) w_next_pass = (w_next_err == 8'h00) && !w_next_aborted;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= ST_IDLE;
            r_vec        <= 4'h0;
            r_settle_cnt <= '0;
            r_pass_cnt   <= '0;
            r_err_count  <= 8'h00;
            r_ff_valid   <= 1'b0;
            r_ff_vec     <= 4'h0;
            r_aborted    <= 1'b0;
            r_pass       <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_drive      <= 4'h0;
        end else begin
            r_state      <= w_next_state;
            r_vec        <= w_next_vec;
            r_settle_cnt <= w_next_settle;
            r_pass_cnt   <= w_next_pass_cnt;
            r_err_count  <= w_next_err;
            r_ff_valid   <= w_next_ff_valid;
            r_ff_vec     <= w_next_ff_vec;
            r_aborted    <= w_next_aborted;
            r_pass       <= w_next_pass;
            r_busy       <= w_busy_next;
            r_done       <= (w_next_state == ST_DONE);
            r_drive      <= w_busy_next ? w_next_vec : 4'h0;
        end
    end

    assign bist_if.dut_sel          = r_drive[3:2];
    assign bist_if.dut_a            = r_drive[1];
    assign bist_if.dut_b            = r_drive[0];
    assign bist_if.busy             = r_busy;
    assign bist_if.done             = r_done;
    assign bist_if.pass             = r_pass;
    assign bist_if.aborted          = r_aborted;
    assign bist_if.err_count        = r_err_count;
    assign bist_if.first_fail_valid = r_ff_valid;
    assign bist_if.first_fail_vec   = r_ff_vec;

endmodule

// File: tb/tb_xnor_gate_bist.sv
// Scoreboard bench for xnor_gate_bist: directed runs push expected results,
// per-instance monitors pop and compare on every DONE pulse.
module tb_xnor_gate_bist;

    typedef enum {CELL_GOLDEN, CELL_STUCK0, CELL_INVERT} cell_t;

    typedef struct {
        int         start_edge;
        int         done_cyc;
        logic       pass;
        logic       aborted;
        logic [7:0] err;
        logic       ffv;
        logic [3:0] ffvec;
    } exp_t;

    logic  clk = 1'b0;
    logic  reset;
    int    cyc_cnt = 0;
    int    n_cmp = 0;
    int    n_err = 0;
    int    start1 = 0;
    int    start40 = 0;
    bit    track1 = 1'b0;
    cell_t mode1 = CELL_GOLDEN;
    cell_t mode40 = CELL_GOLDEN;
    exp_t  q1[$];
    exp_t  q40[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    xnor_gate_bist_if bus1 ();
    xnor_gate_bist_if bus40 ();

    xnor_gate_bist #(.SETTLE_CYCLES(2), .PASSES(1)) u_dut (
        .i_clk   (clk),
        .i_reset (reset),
        .bist_if (bus1.slave)
    );

    xnor_gate_bist #(.SETTLE_CYCLES(2), .PASSES(40)) u_dut40 (
        .i_clk   (clk),
        .i_reset (reset),
        .bist_if (bus40.slave)
    );

    // Cell model: XOR unless sel == 3 (XNOR), with injectable faults.
    function automatic logic cell_model(input cell_t m, input logic [1:0] sel, input logic a, input logic b);
        logic y;
        y = (sel == 2'b11) ? ~(a ^ b) : (a ^ b);
        case (m)
            CELL_STUCK0: return 1'b0;
            CELL_INVERT: return ~y;
            default:     return y;
        endcase
    endfunction

    assign bus1.dut_y  = cell_model(mode1, bus1.dut_sel, bus1.dut_a, bus1.dut_b);
    assign bus40.dut_y = cell_model(mode40, bus40.dut_sel, bus40.dut_a, bus40.dut_b);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic exp_t mk_exp(input int done_cyc, input logic pass, input logic aborted,
                                    input logic [7:0] err, input logic ffv, input logic [3:0] ffvec);
        exp_t e;
        e.start_edge = 0;
        e.done_cyc   = done_cyc;
        e.pass       = pass;
        e.aborted    = aborted;
        e.err        = err;
        e.ffv        = ffv;
        e.ffvec      = ffvec;
        return e;
    endfunction

    task automatic score(input string tag, input exp_t e, input int cyc, input logic busy,
                         input logic [3:0] drv, input logic pass, input logic aborted,
                         input logic [7:0] err, input logic ffv, input logic [3:0] ffvec);
        check({tag, "_done_cycle"}, cyc, e.done_cyc);
        check({tag, "_busy_in_done"}, {31'd0, busy}, 32'd0);
        check({tag, "_drive_in_done"}, {28'd0, drv}, 32'd0);
        check({tag, "_pass"}, {31'd0, pass}, {31'd0, e.pass});
        check({tag, "_aborted"}, {31'd0, aborted}, {31'd0, e.aborted});
        check({tag, "_err_count"}, {24'd0, err}, {24'd0, e.err});
        check({tag, "_ff_valid"}, {31'd0, ffv}, {31'd0, e.ffv});
        check({tag, "_ff_vec"}, {28'd0, ffvec}, {28'd0, e.ffvec});
    endtask

    // Monitor for the single-pass instance: drive sequence while busy, results on DONE.
    always @(negedge clk) begin
        exp_t e;
        int   c;
        c = cyc_cnt - start1 + 1;
        if (track1 && bus1.busy === 1'b1)
            check("vector_drive", {28'd0, bus1.dut_sel, bus1.dut_a, bus1.dut_b}, 32'(((c - 1) / 3) % 16));
        if (bus1.done === 1'b1) begin
            check("done_expected", {31'd0, q1.size() != 0}, 32'd1);
            if (q1.size() != 0) begin
                e = q1.pop_front();
                score("r1", e, cyc_cnt - e.start_edge + 1, bus1.busy,
                      {bus1.dut_sel, bus1.dut_a, bus1.dut_b}, bus1.pass, bus1.aborted,
                      bus1.err_count, bus1.first_fail_valid, bus1.first_fail_vec);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (bus40.done === 1'b1) begin
            check("done40_expected", {31'd0, q40.size() != 0}, 32'd1);
            if (q40.size() != 0) begin
                e = q40.pop_front();
                score("r40", e, cyc_cnt - e.start_edge + 1, bus40.busy,
                      {bus40.dut_sel, bus40.dut_a, bus40.dut_b}, bus40.pass, bus40.aborted,
                      bus40.err_count, bus40.first_fail_valid, bus40.first_fail_vec);
            end
        end
    end

    // Pulses START for one edge; optionally pushes the expected result for that run.
    task automatic start_run(input int inst, input bit push, input exp_t e_in);
        exp_t e;
        e = e_in;
        @(negedge clk);
        if (inst == 1) bus1.start = 1'b1; else bus40.start = 1'b1;
        @(posedge clk);
        #1;
        bus1.start  = 1'b0;
        bus40.start = 1'b0;
        e.start_edge = cyc_cnt;
        if (inst == 1) begin
            start1 = cyc_cnt;
            track1 = 1'b1;
            if (push) q1.push_back(e);
        end else begin
            start40 = cyc_cnt;
            if (push) q40.push_back(e);
        end
    endtask

    task automatic wait_cycle(input int st, input int t);
        while (cyc_cnt - st + 1 < t) @(negedge clk);
    endtask

    task automatic drain(input int inst, input int budget);
        int left;
        left = (inst == 1) ? q1.size() : q40.size();
        for (int i = 0; i < budget && left != 0; i++) begin
            @(posedge clk);
            left = (inst == 1) ? q1.size() : q40.size();
        end
        check((inst == 1) ? "drain_timeout_r1" : "drain_timeout_r40", left, 0);
        if (inst == 1) q1.delete(); else q40.delete();
    endtask

    task automatic check_idle_reset(input string tag);
        check({tag, "_busy"}, {31'd0, bus1.busy}, 32'd0);
        check({tag, "_done"}, {31'd0, bus1.done}, 32'd0);
        check({tag, "_drive"}, {28'd0, bus1.dut_sel, bus1.dut_a, bus1.dut_b}, 32'd0);
        check({tag, "_pass"}, {31'd0, bus1.pass}, 32'd0);
        check({tag, "_aborted"}, {31'd0, bus1.aborted}, 32'd0);
        check({tag, "_err_count"}, {24'd0, bus1.err_count}, 32'd0);
        check({tag, "_ff_valid"}, {31'd0, bus1.first_fail_valid}, 32'd0);
        check({tag, "_ff_vec"}, {28'd0, bus1.first_fail_vec}, 32'd0);
    endtask

    initial begin
        reset          = 1'b1;
        bus1.start     = 1'b0;
        bus1.pwr_good  = 1'b1;
        bus40.start    = 1'b0;
        bus40.pwr_good = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle_reset("reset");
        reset = 1'b0;

        // Golden cell: clean sweep, results held afterwards.
        start_run(1, 1'b1, mk_exp(49, 1'b1, 1'b0, 8'd0, 1'b0, 4'h0));
        drain(1, 70);
        repeat (3) @(negedge clk);
        check("pass_held", {31'd0, bus1.pass}, 32'd1);

        // Y stuck at 0: eight vectors expect 1, first is {00,0,1}.
        mode1 = CELL_STUCK0;
        start_run(1, 1'b1, mk_exp(49, 1'b0, 1'b0, 8'd8, 1'b1, 4'b0001));
        drain(1, 70);
        mode1 = CELL_GOLDEN;

        // Supply drop in cycle 10.
        start_run(1, 1'b1, mk_exp(11, 1'b0, 1'b1, 8'd0, 1'b0, 4'h0));
        wait_cycle(start1, 10);
        bus1.pwr_good = 1'b0;
        @(posedge clk);
        #1 bus1.pwr_good = 1'b1;
        drain(1, 30);

        // START pulses during a run are ignored.
        start_run(1, 1'b1, mk_exp(49, 1'b1, 1'b0, 8'd0, 1'b0, 4'h0));
        wait_cycle(start1, 5);
        bus1.start = 1'b1;
        @(posedge clk);
        #1 bus1.start = 1'b0;
        wait_cycle(start1, 30);
        bus1.start = 1'b1;
        @(posedge clk);
        #1 bus1.start = 1'b0;
        drain(1, 70);
        repeat (6) @(posedge clk);

        // Reset in cycle 20 of a failing run clears everything, no DONE follows.
        mode1 = CELL_STUCK0;
        start_run(1, 1'b0, mk_exp(0, 1'b0, 1'b0, 8'd0, 1'b0, 4'h0));
        wait_cycle(start1, 20);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_idle_reset("mid_reset");
        repeat (40) @(posedge clk);
        mode1 = CELL_GOLDEN;
        start_run(1, 1'b1, mk_exp(49, 1'b1, 1'b0, 8'd0, 1'b0, 4'h0));
        drain(1, 70);

        // START without supply is ignored; previous results stay.
        bus1.pwr_good = 1'b0;
        start_run(1, 1'b0, mk_exp(0, 1'b0, 1'b0, 8'd0, 1'b0, 4'h0));
        @(negedge clk);
        check("nopwr_busy_a", {31'd0, bus1.busy}, 32'd0);
        @(negedge clk);
        check("nopwr_busy_b", {31'd0, bus1.busy}, 32'd0);
        check("nopwr_pass_held", {31'd0, bus1.pass}, 32'd1);
        bus1.pwr_good = 1'b1;
        repeat (3) @(posedge clk);

        // Inverted cell over 40 passes: every vector fails, count saturates.
        mode40 = CELL_INVERT;
        start_run(40, 1'b1, mk_exp(1921, 1'b0, 1'b0, 8'hFF, 1'b1, 4'b0000));
        drain(40, 2000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/xnor_gate_bist.md
# xnor_gate_bist

Self-test driver and checker for the configurable XOR/XNOR cell `xnor_gate`. On START it sweeps all 16 combinations of `{input_state, A, B}`, one combination per check window, into the cell. It samples the cell's Y after a settle window and compares it with the expected function. It reports pass/fail, an error count and the first failing vector. The block sits beside each cell instance in the test harness and on-chip self-test wrapper, on the driving side of the cell's A/B/input_state → Y interface.

## Interface
- SETTLE_CYCLES, 2, number of cycles a vector is held before Y is sampled (≥1)
- PASSES, 1, full 16-vector sweeps per START (≥1)
- CLK  in  1  clock, all logic on rising edge
- RESET  in  1  synchronous, active-high reset
- START  in  1  run request, sampled in IDLE only
- PWR_GOOD  in  1  cell supply valid (VPWR=1, VGND=0), qualified externally
- DUT_Y  in  1  cell output Y
- DUT_A  out  1  drives cell A
- DUT_B  out  1  drives cell B
- DUT_SEL  out  2  drives cell input_state
- BUSY  out  1  sweep in progress
- DONE  out  1  one-cycle completion pulse
- PASS  out  1  last run had zero errors and no abort
- ABORTED  out  1  last run ended early on PWR_GOOD loss
- ERR_COUNT  out  8  mismatches in last run, saturating at 255
- FIRST_FAIL_VALID  out  1  FIRST_FAIL_VEC holds a valid vector
- FIRST_FAIL_VEC  out  4  {SEL[1:0],A,B} of the first mismatch

## Operation
- Expected Y depends on the select value:
  - SEL ≠ 2'b11: Y = A^B.
  - SEL = 2'b11: Y = ~(A^B).
- Vector index `v[3:0]` = {SEL,A,B}. It starts at 0, increments after each check and wraps 15→0 between passes.
- A mismatch is `DUT_Y !== expected`, so an X or Z on Y also counts as a failure in simulation.
- FSM states:
  - IDLE: START=1 and PWR_GOOD=1 → SETTLE. START is ignored while PWR_GOOD=0.
  - SETTLE: counts SETTLE_CYCLES-1 cycles, then → CHECK. With SETTLE_CYCLES=1 it goes → CHECK immediately.
  - CHECK: samples DUT_Y and updates the results.
    - Not the last vector of the last pass: advance v, → SETTLE.
    - Last vector of the last pass: → DONE.
  - DONE: one cycle, DONE=1, then → IDLE.
- Accepting START does the following:
  - clears ERR_COUNT, FIRST_FAIL_*, PASS and ABORTED;
  - sets v=0 and the pass counter to 0.
- DUT_A/B/SEL are registered. They equal v while BUSY and are 0 in IDLE and DONE.
- PASS is set in the DONE cycle when ERR_COUNT=0 and ABORTED=0.
- PASS, ABORTED, ERR_COUNT and FIRST_FAIL_* hold until the next accepted START or RESET.
- ERR_COUNT saturates at 8'hFF and never wraps.
- FIRST_FAIL_VEC is captured only on the first mismatch of a run. Later mismatches leave it unchanged.
- PWR_GOOD=0 in any SETTLE/CHECK cycle:
  - the sample in that cycle is discarded;
  - the FSM goes → DONE with ABORTED=1, PASS=0;
  - ERR_COUNT keeps the errors counted so far.
- START while BUSY or in DONE: ignored; no restart and no queuing.

## Timing
- Reset values: DUT_A=0, DUT_B=0, DUT_SEL=0, BUSY=0, DONE=0, PASS=0, ABORTED=0, ERR_COUNT=0, FIRST_FAIL_VALID=0, FIRST_FAIL_VEC=0. FSM goes to IDLE.
- RESET mid-run aborts immediately, with no DONE pulse.
- Let S=SETTLE_CYCLES and N=16·PASSES. START is sampled high at edge 0.
- BUSY=1 and vector 0 is driven from cycle 1.
- Vector k is driven in cycles 1+k(S+1) … (k+1)(S+1) and sampled in the last of those cycles.
- Last sample occurs at cycle N(S+1).
- DONE=1 at cycle N(S+1)+1.
  - BUSY=0 in that cycle.
  - PASS, ERR_COUNT and FIRST_FAIL_* are final in that cycle.
- Default example: S=2, PASSES=1 → last sample at cycle 48, DONE at cycle 49.
- PWR_GOOD low in cycle t while BUSY → DONE and ABORTED at t+1, DUT drives 0 at t+1.
- The earliest new START is accepted in the cycle after DONE, once the FSM is back in IDLE.

## Test plan
- Golden cell model, S=2, PASSES=1:
  - START @0 → DONE @49, PASS=1, ERR_COUNT=0, FIRST_FAIL_VALID=0;
  - DUT_SEL/A/B step through 0..15, each held 3 cycles.
- DUT_Y stuck at 0 → ERR_COUNT=8, FIRST_FAIL_VEC=4'b0001, PASS=0, DONE @49.
- DUT_Y = inverted golden, PASSES=40 → ERR_COUNT saturates at 255, FIRST_FAIL_VEC=4'b0000, DONE @1921.
- PWR_GOOD deasserted in cycle 10 → DONE @11, ABORTED=1, PASS=0, DUT_A/B/SEL=0 @11.
- START pulsed at cycles 5 and 30 during a run → DONE still @49 only, with a single result.
- RESET at cycle 20 → all outputs at their reset values next cycle with no DONE; a new START is then accepted.
- START with PWR_GOOD=0 → BUSY stays 0.
